// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent down-counting timers (one-shot/periodic, sticky expiry, IRQ)
// behind an 8-bit CPU register window addressed as {ch[2:0], reg[1:0]}.
module multi_timer #(
    parameter int CLK_FRE = 25_175_000,
    parameter int TICK_HZ = 100,
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       R_W_n,
    input  logic [4:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic       timer_cs,
    output logic [7:0] data_o,
    output logic       irq_o
);
    localparam int TICK_DIV = CLK_FRE / TICK_HZ;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUNNING} state_t;

    logic       w_wr, w_rd;
    logic [1:0] w_reg;
    logic [4:0] w_boff;
    logic [7:0] w_rdata [8];
    logic [7:0] w_irq;

    assign w_wr   = timer_cs & ~R_W_n;
    assign w_rd   = timer_cs & R_W_n;
    assign w_reg  = reg_addr_i[1:0];
    assign w_boff = {w_reg - 2'd1, 3'b000};

    genvar c;
    for (c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            state_t          r_st, w_st;
            logic [CNT_W-1:0] r_cnt, w_cnt, r_rld, w_rld, r_shd, w_shd, w_mask, w_wdat;
            logic [PW-1:0]   r_pre, w_pre;
            logic            r_per, w_per, r_ien, w_ien, r_exp, w_exp;
            logic            w_sel, w_ctl, w_set, w_wrap;
            logic [23:0]     w_shd24;

            assign w_sel   = reg_addr_i[4:2] == 3'(c);
            assign w_ctl   = w_wr && w_sel && w_reg == 2'd0;
            assign w_wrap  = r_pre == PMAX;
            assign w_shd24 = 24'(r_shd);
            assign w_mask  = CNT_W'(24'hFF << w_boff);
            assign w_wdat  = CNT_W'({data_i, data_i, data_i});
            assign w_irq[c] = r_exp & r_ien;
            assign w_rdata[c] = w_reg == 2'd0 ? {4'd0, r_ien, r_per, r_exp, r_st == RUNNING} :
                                w_reg == 2'd1 ? r_cnt[7:0] : w_shd24[w_boff +: 8];

            always_comb begin
                w_st  = r_st;
                w_cnt = r_cnt;
                w_pre = r_pre;
                w_set = 1'b0;
                w_per = w_ctl ? data_i[2] : r_per;
                w_ien = w_ctl ? data_i[3] : r_ien;
                w_shd = (w_rd && w_sel && w_reg == 2'd1) ? r_cnt : r_shd;
                w_rld = (w_wr && w_sel && w_reg != 2'd0) ? (r_rld & ~w_mask) | (w_wdat & w_mask) : r_rld;
                if (w_ctl && data_i[1]) begin
                    w_st = IDLE;
                end else if (w_ctl && data_i[0]) begin
                    w_set = r_rld == '0;
                    w_cnt = r_rld;
                    w_pre = '0;
                    w_st  = w_set ? IDLE : RUNNING;
                end else if (r_st == RUNNING) begin
                    w_pre = w_wrap ? '0 : r_pre + 1'b1;
                    // final tick: reload in place so periodic mode loses no cycles
                    if (w_wrap && r_cnt == CNT_W'(1)) begin
                        w_set = 1'b1;
                        w_cnt = (r_per && r_rld != '0) ? r_rld : '0;
                        w_st  = (r_per && r_rld != '0) ? RUNNING : IDLE;
                    end else if (w_wrap) begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end
                w_exp = w_set | (r_exp & ~(w_ctl & data_i[4]));
            end

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_st  <= IDLE;
                    r_cnt <= '0;
                    r_rld <= '0;
                    r_shd <= '0;
                    r_pre <= '0;
                    r_per <= 1'b0;
                    r_ien <= 1'b0;
                    r_exp <= 1'b0;
                end else begin
                    r_st  <= w_st;
                    r_cnt <= w_cnt;
                    r_rld <= w_rld;
                    r_shd <= w_shd;
                    r_pre <= w_pre;
                    r_per <= w_per;
                    r_ien <= w_ien;
                    r_exp <= w_exp;
                end
            end
        end else begin : g_off
            assign w_rdata[c] = 8'd0;
            assign w_irq[c]   = 1'b0;
        end
    end

    assign data_o = w_rdata[reg_addr_i[4:2]];
    assign irq_o  = |w_irq;
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scenarios plus random register traffic, checked every cycle
// against a deadline-based model (expiry at start + load*10 cycles).
module tb_multi_timer;
    logic       clk_i = 1'b0, rst_n_i = 1'b1, R_W_n = 1'b1, timer_cs = 1'b0;
    logic [4:0] reg_addr_i = 5'd0;
    logic [7:0] data_i = 8'd0;
    logic [7:0] data_o;
    logic       irq_o;

    multi_timer #(.CLK_FRE(1000), .TICK_HZ(100), .NUM_CH(2), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
        .data_i(data_i), .timer_cs(timer_cs), .data_o(data_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int m_run[2], m_per[2], m_ien[2], m_exp[2], m_rld[2], m_held[2], m_t0[2], m_load[2], m_shd[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mcount(int i, int k);
        return m_run[i] != 0 ? m_load[i] - (k - m_t0[i]) / 10 : m_held[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_per[i] = 0; m_ien[i] = 0; m_exp[i] = 0; m_rld[i] = 0;
            m_held[i] = 0; m_t0[i] = 0; m_load[i] = 0; m_shd[i] = 0;
        end
    endtask

    task automatic model_edge(input logic cs, input logic rw, input logic [4:0] a, input logic [7:0] d);
        int ch, r, sh, oldper, prev, set;
        logic wr, rd, ctl;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        ch = int'(a[4:2]); r = int'(a[1:0]); wr = cs & ~rw; rd = cs & rw;
        for (int i = 0; i < 2; i++) begin
            ctl = wr && ch == i && r == 0;
            set = 0;
            oldper = m_per[i];
            prev = mcount(i, cyc - 1);
            if (rd && ch == i && r == 1) m_shd[i] = prev;
            if (ctl) begin m_per[i] = int'(d[2]); m_ien[i] = int'(d[3]); end
            if (ctl && d[1]) begin
                if (m_run[i] != 0) begin m_held[i] = prev; m_run[i] = 0; end
            end else if (ctl && d[0]) begin
                if (m_rld[i] == 0) begin set = 1; m_run[i] = 0; m_held[i] = 0; end
                else begin m_run[i] = 1; m_t0[i] = cyc; m_load[i] = m_rld[i]; end
            end else if (m_run[i] != 0 && cyc == m_t0[i] + m_load[i] * 10) begin
                set = 1;
                if (oldper != 0 && m_rld[i] != 0) begin m_t0[i] = cyc; m_load[i] = m_rld[i]; end
                else begin m_run[i] = 0; m_held[i] = 0; end
            end
            if (wr && ch == i && r != 0) begin
                sh = 8 * (r - 1);
                m_rld[i] = ((m_rld[i] & ~(255 << sh)) | (int'(d) << sh)) & 32'hFFFF;
            end
            m_exp[i] = (set != 0 || (m_exp[i] != 0 && !(ctl && d[4]))) ? 1 : 0;
        end
    endtask

    function automatic int model_rd(logic [4:0] a);
        int ch, r;
        ch = int'(a[4:2]); r = int'(a[1:0]);
        if (ch >= 2) return 0;
        if (r == 0) return (m_ien[ch] << 3) | (m_per[ch] << 2) | (m_exp[ch] << 1) | m_run[ch];
        if (r == 1) return mcount(ch, cyc) & 255;
        if (r == 2) return (m_shd[ch] >> 8) & 255;
        return 0;
    endfunction

    task automatic step(input logic cs, input logic rw, input logic [4:0] a, input logic [7:0] d);
        timer_cs = cs; R_W_n = rw; reg_addr_i = a; data_i = d;
        @(posedge clk_i);
        cyc++;
        model_edge(cs, rw, a, d);
        #1;
        check("data_o", 32'(data_o), model_rd(a));
        check("irq_o", 32'(irq_o), ((m_exp[0] & m_ien[0]) | (m_exp[1] & m_ien[1])));
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b1, 1'b1, a, 8'd0);
    endtask

    task automatic idle(input int n, input logic [4:0] a);
        repeat (n) step(1'b0, 1'b1, a, 8'd0);
    endtask

    initial begin
        int op;
        logic [4:0] a;
        logic [7:0] d;
        logic [2:0] ch;
        model_reset();
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_ctrl", 32'(data_o), 0);
        check("rst_irq", 32'(irq_o), 0);
        idle(2, 5'h00);
        #3 rst_n_i = 1'b1;
        // one-shot ch0, reload 3
        wr(5'h01, 8'd3); wr(5'h02, 8'd0); wr(5'h00, 8'h01);
        idle(29, 5'h00);
        check("t1_running", 32'(data_o), 32'h01);
        idle(1, 5'h00);
        check("t1_expired", 32'(data_o), 32'h02);
        check("t1_irq", 32'(irq_o), 0);
        wr(5'h00, 8'h10);
        // periodic ch1 with irq, reload 2
        wr(5'h05, 8'd2); wr(5'h06, 8'd0); wr(5'h04, 8'h0D);
        idle(20, 5'h04);
        check("t2_exp1", 32'(data_o), 32'h0F);
        check("t2_irq1", 32'(irq_o), 1);
        rd(5'h05);
        check("t2_reloaded", 32'(data_o), 32'h02);
        wr(5'h04, 8'h1C);
        check("t2_clr", 32'(data_o), 32'h0D);
        check("t2_irq_clr", 32'(irq_o), 0);
        idle(18, 5'h04);
        check("t2_exp2", 32'(data_o), 32'h0F);
        check("t2_irq2", 32'(irq_o), 1);
        wr(5'h04, 8'h02);
        check("t2_stop", 32'(data_o), 32'h02);
        wr(5'h04, 8'h10);
        // snapshot and stop-hold on ch0, reload 0x0105
        wr(5'h01, 8'h05); wr(5'h02, 8'h01); wr(5'h00, 8'h01);
        idle(37, 5'h00);
        rd(5'h01);
        check("t3_cnt_lo", 32'(data_o), 32'h02);
        rd(5'h02);
        check("t3_shd_hi", 32'(data_o), 32'h01);
        rd(5'h03);
        check("t3_top_byte", 32'(data_o), 0);
        idle(5, 5'h01);
        wr(5'h00, 8'h02);
        idle(30, 5'h01);
        check("t3_hold", 32'(data_o), 32'h01);
        wr(5'h00, 8'h03);
        check("t3_stop_wins", 32'(data_o), 0);
        // CLR_EXP on the expiry edge, then START with reload 0
        wr(5'h01, 8'd3); wr(5'h02, 8'd0); wr(5'h00, 8'h01);
        idle(29, 5'h00);
        wr(5'h00, 8'h10);
        check("t4_set_wins", 32'(data_o), 32'h02);
        wr(5'h00, 8'h10); wr(5'h01, 8'd0); wr(5'h00, 8'h01);
        check("t4_zero_start", 32'(data_o), 32'h02);
        rd(5'h01);
        check("t4_zero_cnt", 32'(data_o), 0);
        wr(5'h00, 8'h10);
        // async reset with both channels counting
        wr(5'h01, 8'h05); wr(5'h02, 8'h01); wr(5'h00, 8'h01);
        wr(5'h05, 8'd4); wr(5'h06, 8'd0); wr(5'h04, 8'h0D);
        idle(15, 5'h00);
        #3 rst_n_i = 1'b0;
        #1 model_reset();
        check("t5_rst_ctrl0", 32'(data_o), 0);
        check("t5_rst_irq", 32'(irq_o), 0);
        reg_addr_i = 5'h04;
        #1 check("t5_rst_ctrl1", 32'(data_o), 0);
        idle(2, 5'h04);
        #3 rst_n_i = 1'b1;
        idle(60, 5'h04);
        check("t5_no_expiry", 32'(data_o), 0);
        check("t5_no_irq", 32'(irq_o), 0);
        rd(5'h15);
        check("t5_ch5_rd", 32'(data_o), 0);
        wr(5'h14, 8'h0D);
        rd(5'h14);
        check("t5_ch5_ctrl", 32'(data_o), 0);
        // random register traffic
        for (int n = 0; n < 4000; n++) begin
            op = $urandom_range(0, 9);
            a = 5'($urandom);
            ch = 3'($urandom_range(0, 2));
            if (op <= 5) begin
                step(1'b0, 1'b1, a, 8'd0);
            end else if (op == 6) begin
                d = 8'($urandom);
                if ($urandom_range(0, 3) != 0) d[1] = 1'b0;
                wr({ch, 2'd0}, d);
            end else if (op == 7) begin
                wr({ch, 2'd1}, 8'($urandom_range(0, 6)));
            end else if (op == 8) begin
                d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
                wr({ch, 2'($urandom_range(2, 3))}, d);
            end else begin
                rd({ch, 2'($urandom_range(1, 2))});
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
